udiv_seq: RTL and testbench

Sequential 8-bit by 4-bit unsigned divider. It is the inverse companion of the team's 4x4 combinational unsigned multiplier: `dividend = quotient * divisor + remainder`. It uses restoring division, producing one quotient bit per clock, with a start/done handshake. It sits beside the multiplier in the ALU datapath and feeds the result registers.

---
 rtl/udiv_seq_if.sv | 25 ++
 rtl/udiv_seq.sv | 116 +++++++++++
 tb/tb_udiv_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/udiv_seq_if.sv
// Operand/result bundle for the sequential 8/4 unsigned divider.
// Handshake: start is taken only in a cycle where ready=1; ready, busy and done
// are mutually exclusive state decodes, and done is a one-cycle pulse that
// marks the cycle in which quotient/remainder/div_by_zero have just updated.
interface udiv_seq_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/udiv_seq.sv
// Sequential 8-bit by 4-bit restoring divider, one quotient bit per clock.
// Results are registered and change only on the edge that enters DONE.
module udiv_seq (
  input  logic        clk,
  input  logic        rst,
  udiv_seq_if.slave   bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] sr;
  logic [3:0] dvs;
  logic [3:0] r;
  logic [2:0] cnt;

  logic [4:0] t;
  logic       q_bit;
  logic [3:0] r_next;

  logic [7:0] quot;
  logic [3:0] rem;
  logic       dbz;

  // The partial remainder's fifth bit is always zero after a step, so only
  // the low four bits are stored; the compare itself is done at five bits.
  always_comb begin
    t      = {r, sr[7]};
    q_bit  = (t >= {1'b0, dvs});
    r_next = q_bit ? (t[3:0] - dvs) : t[3:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.divisor == 4'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == 3'd0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= 8'd0;
      dvs  <= 4'd0;
      r    <= 4'd0;
      cnt  <= 3'd0;
      quot <= 8'd0;
      rem  <= 4'd0;
      dbz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != 4'd0) begin
              dvs <= bus.divisor;
              r   <= 4'd0;
              sr  <= bus.dividend;
              cnt <= 3'd7;
            end else begin
              quot <= 8'hFF;
              rem  <= bus.dividend[3:0];
              dbz  <= 1'b1;
            end
          end
        end
        CALC: begin
          // Quotient bits enter at the LSB as dividend bits leave at the MSB.
          r   <= r_next;
          sr  <= {sr[6:0], q_bit};
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            quot <= {sr[6:0], q_bit};
            rem  <= r_next;
            dbz  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready       = (state == IDLE);
  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quot;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
  assign dbg_state       = state;

endmodule

// File: tb/tb_udiv_seq.sv
// Bench for udiv_seq: directed vectors with literal results, random vectors
// checked against plain division, per-cycle handshake and result-hold checks.
module tb_udiv_seq;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;
  int         n_cmp;
  int         n_err;

  udiv_seq_if bus ();

  udiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
    bit         rnd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] held_q;
  logic [3:0] held_r;
  logic       held_dz;

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: wait for the first ready cycle, present the operation for one edge
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q,
                       input logic [3:0] r, input logic dz, input bit rnd);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("ready_wait", {31'd0, got}, 32'd1);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    e.a   = a;
    e.b   = b;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    e.rnd = rnd;
    e.cyc = cyc + 1 + ((b == 4'd0) ? 0 : 8);
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_wait", {31'd0, got}, 32'd1);
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (!rst) begin
      chk("one_hot_hs", {30'd0, 2'(bus.ready) + 2'(bus.busy) + 2'(bus.done)}, 32'd1);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'd0, bus.done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("quotient", {24'd0, bus.quotient}, {24'd0, e.q});
          chk("remainder", {28'd0, bus.remainder}, {28'd0, e.r});
          chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
          chk("done_latency", cyc, e.cyc);
          if (e.rnd && e.b != 4'd0) begin
            chk("q*d+r", 32'(bus.quotient) * 32'(e.b) + 32'(bus.remainder), 32'(e.a));
            chk("r<d", {31'd0, (bus.remainder < e.b)}, 32'd1);
          end
          held_q  = e.q;
          held_r  = e.r;
          held_dz = e.dz;
        end
      end else begin
        chk("hold_q", {24'd0, bus.quotient}, {24'd0, held_q});
        chk("hold_r", {28'd0, bus.remainder}, {28'd0, held_r});
        chk("hold_dz", {31'd0, bus.div_by_zero}, {31'd0, held_dz});
      end
    end
  end

  initial begin
    logic [7:0] a;
    logic [3:0] b;
    bit         drained;
    cyc          = 0;
    n_cmp        = 0;
    n_err        = 0;
    held_q       = 8'd0;
    held_r       = 4'd0;
    held_dz      = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;

    // reset: two cycles, check during and after
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", {31'd0, bus.ready}, 32'd1);
    chk("rel_q", {24'd0, bus.quotient}, 32'h00);
    chk("rel_r", {28'd0, bus.remainder}, 32'h0);
    chk("rel_dz", {31'd0, bus.div_by_zero}, 32'd0);
    chk("rel_done", {31'd0, bus.done}, 32'd0);

    // directed vectors, hand-computed results
    do_op(8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 1'b0);
    do_op(8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 1'b0);
    do_op(8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 1'b0);
    do_op(8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 1'b0);
    do_op(8'd100, 4'd0,  8'hFF,  4'h4, 1'b1, 1'b0);
    do_op(8'd9,   4'd3,  8'd3,   4'd0, 1'b0, 1'b0);

    // start pulses and operand churn during CALC and DONE are ignored
    do_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 4'd5;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'd77;
    bus.divisor  = 4'd0;
    wait_done();
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 4'd5;
    @(negedge clk);
    bus.start    = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignored_start_q", {31'd0, (exp_q.size() == 0)}, 32'd1);

    // asynchronous reset at CALC cycle 4
    do_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    held_q  = 8'd0;
    held_r  = 4'd0;
    held_dz = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_q", {24'd0, bus.quotient}, 32'd0);
    chk("mid_rst_r", {28'd0, bus.remainder}, 32'd0);
    chk("mid_rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd13, 4'd4, 8'd3, 4'd1, 1'b0, 1'b0);

    // back-to-back random operations, model = plain division
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom_range(0, 255));
      if (i == 0)      b = 4'd0;
      else if (i == 1) b = 4'd1;
      else if (i == 2) b = 4'd15;
      else             b = 4'($urandom_range(0, 15));
      if (b == 4'd0) do_op(a, b, 8'hFF, a[3:0], 1'b1, 1'b1);
      else           do_op(a, b, a / 8'(b), 4'(a % 8'(b)), 1'b0, 1'b1);
    end

    drained = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    chk("drain", {31'd0, drained}, 32'd1);
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
